// File: rtl/run_length_detector.sv
// run_length_detector: Moore detector for runs of ZERO_LEN 0s / ONE_LEN 1s with saturating run counter.
// Define MATCH_COUNT_EN to add the saturating match_cnt detection-event counter.
module run_length_detector #(
  parameter int ZERO_LEN = 4,
  parameter int ONE_LEN  = 4,
  parameter int CNT_W    = 4,
  parameter int MCNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             w,
  input  logic [1:0]       mode,
  output logic             z,
  output logic             z_zero,
  output logic             z_one,
`ifdef MATCH_COUNT_EN
  output logic [MCNT_W-1:0] match_cnt,
`endif
  output logic [CNT_W-1:0] run_len
);
  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_ZCNT = 3'b001,
    S_ZHIT = 3'b010,
    S_OCNT = 3'b101,
    S_OHIT = 3'b100
  } state_t;
  localparam logic [CNT_W-1:0] ZL = CNT_W'(ZERO_LEN);
  localparam logic [CNT_W-1:0] OL = CNT_W'(ONE_LEN);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic zrun, orun, cont;
  always_comb begin
    zrun    = state_q == S_ZCNT || state_q == S_ZHIT;
    orun    = state_q == S_OCNT || state_q == S_OHIT;
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    cont    = (zrun && !w) || (orun && w);
    state_d = state_q;
    cnt_d   = cnt_q;
    // Unused encodings recover to idle regardless of en
    if (!(zrun || orun || state_q == S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else if (en && cont) begin
      cnt_d   = cnt_inc;
      state_d = zrun ? ((state_q == S_ZHIT || cnt_inc == ZL) ? S_ZHIT : S_ZCNT)
                     : ((state_q == S_OHIT || cnt_inc == OL) ? S_OHIT : S_OCNT);
    end else if (en) begin
      cnt_d   = CNT_W'(1);
      state_d = w ? ((ONE_LEN == 1) ? S_OHIT : S_OCNT) : ((ZERO_LEN == 1) ? S_ZHIT : S_ZCNT);
    end
  end
`ifdef MATCH_COUNT_EN
  logic [MCNT_W-1:0] match_q;
  logic hit_evt;
  assign hit_evt = en && state_d != state_q &&
                   ((state_d == S_ZHIT && mode[0]) || (state_d == S_OHIT && mode[1]));
  always_ff @(posedge clk)
    if (reset) match_q <= '0;
    else if (hit_evt && !(&match_q)) match_q <= match_q + 1'b1;
  assign match_cnt = match_q;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign z_zero  = state_q == S_ZHIT && mode[0];
  assign z_one   = state_q == S_OHIT && mode[1];
  assign z       = z_zero | z_one;
  assign run_len = cnt_q;
endmodule

// File: tb/tb_run_length_detector.sv
// tb_run_length_detector: scoreboard bench; run-length reference model drives expectations.
module tb_run_length_detector;
  localparam int ZL = 4, OL = 4, CW = 4, MW = 8;
  typedef struct packed {
    logic          z, zz, zo;
    logic [CW-1:0] rl;
    logic [MW-1:0] mc;
  } exp_t;
  logic clk = 0, reset = 1, en = 0, w = 0;
  logic [1:0] mode = 2'b11;
  logic z, z_zero, z_one;
  logic [CW-1:0] run_len;
  logic [MW-1:0] mc_dut;
  exp_t exp_q[$];
  int n_vec = 0, n_err = 0;
  int run = 0, mc = 0;
  logic last = 0;
  run_length_detector #(.ZERO_LEN(ZL), .ONE_LEN(OL), .CNT_W(CW), .MCNT_W(MW)) dut (
    .clk(clk), .reset(reset), .en(en), .w(w), .mode(mode),
    .z(z), .z_zero(z_zero), .z_one(z_one),
`ifdef MATCH_COUNT_EN
    .match_cnt(mc_dut),
`endif
    .run_len(run_len)
  );
`ifndef MATCH_COUNT_EN
  assign mc_dut = '0;
`endif
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic b, input logic [1:0] m);
    exp_t x;
    @(negedge clk);
    reset = r; en = e; w = b; mode = m;
    if (r) begin
      run = 0; mc = 0;
    end else if (e) begin
      if (run > 0 && b == last) run++;
      else begin run = 1; last = b; end
      if (run == (b ? OL : ZL) && m[b] && mc < 2**MW - 1) mc++;
    end
    x.zz = run >= ZL && last == 1'b0 && m[0];
    x.zo = run >= OL && last == 1'b1 && m[1];
    x.z  = x.zz | x.zo;
    x.rl = CW'(run > 2**CW - 1 ? 2**CW - 1 : run);
`ifdef MATCH_COUNT_EN
    x.mc = MW'(mc);
`else
    x.mc = '0;
`endif
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int want);
    n_vec++;
    if (act != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  initial forever begin
    exp_t x;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      chk("z", int'(z), int'(x.z));
      chk("z_zero", int'(z_zero), int'(x.zz));
      chk("z_one", int'(z_one), int'(x.zo));
      chk("run_len", int'(run_len), int'(x.rl));
`ifdef MATCH_COUNT_EN
      chk("match_cnt", int'(mc_dut), int'(x.mc));
`endif
    end
  end

  initial begin
    logic b;
    step(1, 0, 0, 2'b11);
    repeat (4) step(0, 1, 0, 2'b11);
    step(1, 0, 0, 2'b11);
    repeat (3) step(0, 1, 0, 2'b11);
    repeat (4) step(0, 1, 1, 2'b11);
    repeat (20) step(0, 1, 1, 2'b11);
    step(0, 1, 0, 2'b11);
    step(1, 0, 0, 2'b11);
    repeat (2) step(0, 1, 0, 2'b11);
    for (int i = 0; i < 5; i++) step(0, 0, i[0], 2'b11);
    repeat (2) step(0, 1, 0, 2'b11);
    step(1, 0, 0, 2'b01);
    repeat (4) step(0, 1, 1, 2'b01);
    step(0, 0, 0, 2'b11);
    step(0, 0, 0, 2'b10);
    step(1, 0, 0, 2'b11);
    repeat (4) step(0, 1, 0, 2'b11);
    step(1, 1, 0, 2'b11);
    for (int k = 0; k < 3; k++) begin
      repeat (4) step(0, 1, 0, 2'b11);
      step(0, 1, 1, 2'b11);
    end
    b = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) b = ~b;
      step($urandom_range(60) == 0, $urandom_range(3) != 0, b, 2'($urandom));
    end
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
